// File: rtl/mcpu_core_int_ctrl.sv
// Interrupt controller: edge-detects irq lines, tracks pending/mask state and
// offers the lowest-index eligible source to the pipeline until it is taken.
module mcpu_core_int_ctrl #(
  parameter int unsigned NUM_IRQ = 8
) (
  input  logic               clkrst_core_clk,
  input  logic               clkrst_core_rst,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               interrupts_enabled,
  input  logic               int_take,
  input  logic               eret,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wdata,
  input  logic               pend_clr_we,
  input  logic [NUM_IRQ-1:0] pend_clr_bits,
  output logic               int_req,
  output logic [3:0]         int_type,
  output logic               in_handler,
  output logic [NUM_IRQ-1:0] pending_rdata,
  output logic [NUM_IRQ-1:0] mask_rdata
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_SERVICE} state_t;

  state_t             state, state_nxt;
  logic [NUM_IRQ-1:0] irq_prev, pending, mask;
  logic [NUM_IRQ-1:0] edge_vec, eligible, pending_nxt, sel_onehot;
  logic [3:0]         sel, sel_nxt, enc_idx;
  logic               enc_valid, sel_live, take;

  always_comb begin
    edge_vec  = irq_in & ~irq_prev;
    eligible  = pending & mask;
    take      = (state == ST_REQ) && int_take;
    enc_idx   = '0;
    enc_valid = 1'b0;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      if (!enc_valid && eligible[i]) begin
        enc_idx   = 4'(i);
        enc_valid = 1'b1;
      end
    end
    sel_onehot = '0;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      sel_onehot[i] = (sel == 4'(i));
    end
    sel_live = |(eligible & sel_onehot);
  end

  // Edge set beats software clear, which beats the take clear.
  always_comb begin
    pending_nxt = pending;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      if (edge_vec[i])
        pending_nxt[i] = 1'b1;
      else if (pend_clr_we && pend_clr_bits[i])
        pending_nxt[i] = 1'b0;
      else if (take && sel_onehot[i])
        pending_nxt[i] = 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    case (state)
      ST_IDLE: begin
        if (interrupts_enabled && enc_valid) begin
          sel_nxt   = enc_idx;
          state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        if (int_take)
          state_nxt = ST_SERVICE;
        else if (!interrupts_enabled || !sel_live)
          state_nxt = ST_IDLE;
      end
      ST_SERVICE: begin
        if (eret)
          state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clkrst_core_clk or posedge clkrst_core_rst) begin
    if (clkrst_core_rst) begin
      state    <= ST_IDLE;
      sel      <= '0;
      irq_prev <= '0;
      pending  <= '0;
      mask     <= '0;
    end else begin
      state    <= state_nxt;
      sel      <= sel_nxt;
      irq_prev <= irq_in;
      pending  <= pending_nxt;
      if (mask_we)
        mask <= mask_wdata;
    end
  end

  assign int_req       = (state == ST_REQ);
  assign int_type      = int_req ? (sel + 4'd1) : '0;
  assign in_handler    = (state == ST_SERVICE);
  assign pending_rdata = pending;
  assign mask_rdata    = mask;

endmodule

// File: tb/tb_mcpu_core_int_ctrl.sv
// Directed bench for mcpu_core_int_ctrl with hand-computed expectations.
module tb_mcpu_core_int_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] irq_in;
  logic       interrupts_enabled, int_take, eret, mask_we, pend_clr_we;
  logic [7:0] mask_wdata, pend_clr_bits;
  logic       int_req, in_handler;
  logic [3:0] int_type;
  logic [7:0] pending_rdata, mask_rdata;

  int n_checks = 0;
  int n_pass   = 0;

  mcpu_core_int_ctrl #(.NUM_IRQ(8)) dut (
    .clkrst_core_clk    (clk),
    .clkrst_core_rst    (rst),
    .irq_in             (irq_in),
    .interrupts_enabled (interrupts_enabled),
    .int_take           (int_take),
    .eret               (eret),
    .mask_we            (mask_we),
    .mask_wdata         (mask_wdata),
    .pend_clr_we        (pend_clr_we),
    .pend_clr_bits      (pend_clr_bits),
    .int_req            (int_req),
    .int_type           (int_type),
    .in_handler         (in_handler),
    .pending_rdata      (pending_rdata),
    .mask_rdata         (mask_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_irq(input logic [7:0] lines);
    irq_in = lines;
    tick();
    irq_in = '0;
  endtask

  task automatic write_mask(input logic [7:0] m);
    mask_we = 1'b1; mask_wdata = m;
    tick();
    mask_we = 1'b0;
  endtask

  // Take is only legal while a request is offered.
  task automatic take();
    check("take_protocol", 32'(int_req), 32'd1);
    int_take = 1'b1;
    tick();
    int_take = 1'b0;
  endtask

  task automatic do_eret();
    eret = 1'b1;
    tick();
    eret = 1'b0;
  endtask

  task automatic check_req(input string tag, input logic req, input logic [3:0] typ);
    check({tag, "_req"}, 32'(int_req), 32'(req));
    check({tag, "_type"}, 32'(int_type), 32'(typ));
  endtask

  initial begin
    rst = 1'b1; irq_in = '0; interrupts_enabled = 1'b0; int_take = 1'b0; eret = 1'b0;
    mask_we = 1'b0; mask_wdata = '0; pend_clr_we = 1'b0; pend_clr_bits = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    check_req("reset", 1'b0, 4'd0);
    check("reset_in_handler", 32'(in_handler), 32'd0);
    check("reset_pending", 32'(pending_rdata), 32'h00);
    check("reset_mask", 32'(mask_rdata), 32'h00);

    // Basic delivery
    write_mask(8'hFF);
    interrupts_enabled = 1'b1;
    check("mask_ff", 32'(mask_rdata), 32'hFF);
    pulse_irq(8'h08);
    check("basic_pend", 32'(pending_rdata), 32'h08);
    check_req("basic_n1", 1'b0, 4'd0);
    tick();
    check_req("basic_n2", 1'b1, 4'd4);
    tick(); tick();
    check_req("basic_hold", 1'b1, 4'd4);
    take();
    check("basic_take_req", 32'(int_req), 32'd0);
    check("basic_take_ih", 32'(in_handler), 32'd1);
    check("basic_take_pend", 32'(pending_rdata), 32'h00);
    tick(); tick();
    do_eret();
    check("basic_eret_ih", 32'(in_handler), 32'd0);
    tick();
    check_req("basic_idle", 1'b0, 4'd0);

    // Priority: 2 before 5, then 5 offered two cycles after eret
    pulse_irq(8'h24);
    check("prio_pend", 32'(pending_rdata), 32'h24);
    tick();
    check_req("prio_first", 1'b1, 4'd3);
    take();
    check("prio_pend_after_take", 32'(pending_rdata), 32'h20);
    check("prio_ih", 32'(in_handler), 32'd1);
    do_eret();
    check_req("prio_e1", 1'b0, 4'd0);
    tick();
    check_req("prio_e2", 1'b1, 4'd6);

    // Stability: higher-priority edge does not re-prioritise a live request
    pulse_irq(8'h01);
    check("stab_pend", 32'(pending_rdata), 32'h21);
    check_req("stab_1", 1'b1, 4'd6);
    tick();
    check_req("stab_2", 1'b1, 4'd6);
    write_mask(8'hDF);
    check("stab_mask_vis", 32'(mask_rdata), 32'hDF);
    check_req("stab_mask_vis", 1'b1, 4'd6);
    tick();
    check_req("withdraw", 1'b0, 4'd0);
    tick();
    check_req("after_withdraw", 1'b1, 4'd1);
    take();
    check("stab_pend_take", 32'(pending_rdata), 32'h20);
    pend_clr_we = 1'b1; pend_clr_bits = 8'h20;
    tick();
    pend_clr_we = 1'b0; pend_clr_bits = '0;
    check("swclr", 32'(pending_rdata), 32'h00);
    write_mask(8'hFF);
    do_eret();
    tick();
    check_req("stab_idle", 1'b0, 4'd0);

    // Global disable
    interrupts_enabled = 1'b0;
    pulse_irq(8'h02);
    check("dis_pend", 32'(pending_rdata), 32'h02);
    tick(); tick();
    check_req("dis_hold", 1'b0, 4'd0);
    interrupts_enabled = 1'b1;
    tick();
    check_req("dis_enable", 1'b1, 4'd2);
    take();
    do_eret();

    // Simultaneous set and clear
    pulse_irq(8'h04);
    tick();
    check_req("sim_req", 1'b1, 4'd3);
    irq_in = 8'h04;
    take();
    irq_in = '0;
    check("sim_take_edge", 32'(pending_rdata), 32'h04);
    check("sim_ih", 32'(in_handler), 32'd1);
    pend_clr_we = 1'b1; pend_clr_bits = 8'h10; irq_in = 8'h10;
    tick();
    irq_in = '0;
    check("sim_clr_edge", 32'(pending_rdata), 32'h14);
    pend_clr_bits = 8'h14;
    tick();
    pend_clr_we = 1'b0; pend_clr_bits = '0;
    check("sim_clr", 32'(pending_rdata), 32'h00);
    do_eret();

    // Reset mid-request
    pulse_irq(8'h40);
    tick();
    check_req("rst_pre", 1'b1, 4'd7);
    irq_in = 8'h80;
    rst = 1'b1;
    #1;
    check_req("rst_async", 1'b0, 4'd0);
    check("rst_async_ih", 32'(in_handler), 32'd0);
    check("rst_async_pend", 32'(pending_rdata), 32'h00);
    check("rst_async_mask", 32'(mask_rdata), 32'h00);
    tick();
    rst = 1'b0;
    tick();
    check("rst_held_line", 32'(pending_rdata), 32'h80);
    check("rst_held_req", 32'(int_req), 32'd0);
    tick();
    check("rst_one_edge", 32'(pending_rdata), 32'h80);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
